// File: rtl/twodisplays_decoder.sv
// Two-digit seven-segment bus decoder with stability filter,
// error classification and a once-per-reading valid/ready offer.
module twodisplays_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] displays,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [3:0]  value,
    output logic [1:0]  err_code,
    output logic [7:0]  err_count
);

    typedef enum logic {TRACK, OFFER} state_t;

    state_t      state_q, state_d;
    logic [13:0] disp_q, last_pat, cap_pat;
    logic [7:0]  stab_cnt;
    logic        have_last;
    logic        stable;
    logic        load, take;

    logic [6:0]  tp, up;
    logic [3:0]  u;
    logic        u_ok, t, t_ok;
    logic [4:0]  raw;
    logic [1:0]  dec_err;
    logic [3:0]  dec_val;

    assign stable = (stab_cnt == 8'(STABLE_CYCLES));
    assign tp     = disp_q[13:7];
    assign up     = disp_q[6:0];

    always_comb begin
        u    = 4'd0;
        u_ok = 1'b1;
        case (up)
            7'b0000001: u = 4'd0;
            7'b1001111: u = 4'd1;
            7'b0010010: u = 4'd2;
            7'b0000110: u = 4'd3;
            7'b1001100: u = 4'd4;
            7'b0100100: u = 4'd5;
            7'b0100000: u = 4'd6;
            7'b0001111: u = 4'd7;
            7'b0000000: u = 4'd8;
            7'b0000100: u = 4'd9;
            default:    u_ok = 1'b0;
        endcase
    end

    always_comb begin
        t    = 1'b0;
        t_ok = 1'b1;
        case (tp)
            7'b0000001: t = 1'b0;
            7'b1001111: t = 1'b1;
            default:    t_ok = 1'b0;
        endcase
    end

    always_comb begin
        raw = t ? 5'd10 + {1'b0, u} : {1'b0, u};
        if (!t_ok)
            dec_err = 2'd1;
        else if (!u_ok)
            dec_err = 2'd2;
        else if (raw > 5'd15)
            dec_err = 2'd3;
        else
            dec_err = 2'd0;
        dec_val = (dec_err == 2'd0) ? raw[3:0] : 4'd0;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            TRACK: begin
                if (stable && (!have_last || disp_q != last_pat)) begin
                    load    = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (out_ready) begin
                    take    = 1'b1;
                    state_d = TRACK;
                end
            end
            default: state_d = TRACK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= TRACK;
            disp_q    <= 14'h3FFF;
            stab_cnt  <= 8'd0;
            have_last <= 1'b0;
            last_pat  <= 14'h3FFF;
            cap_pat   <= 14'h3FFF;
            out_valid <= 1'b0;
            value     <= 4'd0;
            err_code  <= 2'd0;
            err_count <= 8'd0;
        end else begin
            state_q <= state_d;
            disp_q  <= displays;
            if (displays != disp_q)
                stab_cnt <= 8'd0;
            else if (!stable)
                stab_cnt <= stab_cnt + 8'd1;
            if (load) begin
                cap_pat   <= disp_q;
                value     <= dec_val;
                err_code  <= dec_err;
                out_valid <= 1'b1;
            end
            if (take) begin
                out_valid <= 1'b0;
                last_pat  <= cap_pat;
                have_last <= 1'b1;
                if (err_code != 2'd0 && err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_twodisplays_decoder.sv
// Directed, table-driven bench for twodisplays_decoder.
// Transfers are logged on the falling edge.
module tb_twodisplays_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] displays;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  value;
    logic [1:0]  err_code;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;
    int vcyc  = 0;
    int xfers = 0;
    int lastv = -1;
    int laste = -1;

    localparam logic [13:0] P09 = 14'b0000001_0000100;
    localparam logic [13:0] P15 = 14'b1001111_0100100;
    localparam logic [13:0] P12 = 14'b1001111_0010010;
    localparam logic [13:0] P13 = 14'b1001111_0000110;
    localparam logic [13:0] P05 = 14'b0000001_0100100;
    localparam logic [13:0] P07 = 14'b0000001_0001111;
    localparam logic [13:0] E3  = 14'b1001111_0100000;
    localparam logic [13:0] E1  = 14'b1111111_0000001;
    localparam logic [13:0] E2  = 14'b0000001_1111110;

    typedef struct {
        logic [13:0] disp;
        int          hold;
        int          val;
        int          err;
    } vec_t;

    vec_t tbl[7];

    twodisplays_decoder #(.STABLE_CYCLES(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .displays(displays),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .value(value),
        .err_code(err_code),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            vcyc++;
            if (out_ready) begin
                xfers++;
                lastv = int'(value);
                laste = int'(err_code);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_emit(input string name, input int v);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk({name, " early valid"}, int'(out_valid), 0);
        end
        tick();
        chk({name, " valid"}, int'(out_valid), 1);
        chk({name, " value"}, int'(value), v);
        chk({name, " err"}, int'(err_code), 0);
    endtask

    initial begin
        int x0, v0;
        tbl[0] = '{P09, 20, 9, 0};
        tbl[1] = '{P05, 10, 5, 0};
        tbl[2] = '{P07, 10, 7, 0};
        tbl[3] = '{P05, 10, 5, 0};
        tbl[4] = '{E3, 10, 0, 3};
        tbl[5] = '{E1, 10, 0, 1};
        tbl[6] = '{E2, 10, 0, 2};

        rst_n     = 1'b0;
        displays  = 14'h3FFF;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst valid", int'(out_valid), 0);
        chk("rst value", int'(value), 0);
        chk("rst err", int'(err_code), 0);
        chk("rst errcnt", int'(err_count), 0);
        rst_n = 1'b1;

        // exact latency: sampled at edge k, valid after edge k+5
        displays = P09;
        wait_emit("lat09", 9);
        out_ready = 1'b1;
        tick();
        chk("lat09 drop", int'(out_valid), 0);

        // held offer with backpressure, then back-to-back transfers
        out_ready = 1'b0;
        displays  = P15;
        for (int i = 0; i < 10; i++) tick();
        chk("bp valid", int'(out_valid), 1);
        chk("bp value", int'(value), 15);
        displays = P12;
        v0 = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || value !== 4'd15) v0++;
        end
        chk("bp frozen", v0, 0);
        out_ready = 1'b1;
        x0 = xfers;
        tick();
        chk("bp xfer15", lastv, 15);
        chk("bp gap", int'(out_valid), 0);
        tick();
        chk("bp valid12", int'(out_valid), 1);
        chk("bp value12", int'(value), 12);
        tick();
        chk("bp xfer12", lastv, 12);
        chk("bp after", int'(out_valid), 0);
        chk("bp nxfer", xfers - x0, 2);

        // reset during offer abandons the reading
        out_ready = 1'b0;
        displays  = P13;
        for (int i = 0; i < 10; i++) tick();
        chk("rs valid", int'(out_valid), 1);
        chk("rs value", int'(value), 13);
        x0 = xfers;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rs drop", int'(out_valid), 0);
        chk("rs errcnt", int'(err_count), 0);
        chk("rs noxfer", xfers - x0, 0);
        wait_emit("rs13", 13);
        out_ready = 1'b1;
        tick();
        chk("rs xfer13", lastv, 13);

        for (int i = 0; i < 7; i++) begin
            x0 = xfers;
            v0 = vcyc;
            displays = tbl[i].disp;
            for (int c = 0; c < tbl[i].hold; c++) tick();
            chk($sformatf("tbl%0d nxfer", i), xfers - x0, 1);
            chk($sformatf("tbl%0d vcyc", i), vcyc - v0, 1);
            chk($sformatf("tbl%0d value", i), lastv, tbl[i].val);
            chk($sformatf("tbl%0d err", i), laste, tbl[i].err);
        end
        chk("errcnt", int'(err_count), 3);

        // short-lived patterns never pass the filter
        v0 = vcyc;
        for (int i = 0; i < 20; i++) begin
            displays = i[0] ? P07 : P05;
            tick();
            tick();
        end
        chk("glitch vcyc", vcyc - v0, 0);
        chk("glitch errcnt", int'(err_count), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/twodisplays_decoder.md
# twodisplays_decoder

Receive-side counterpart of the two-digit seven-segment encoder. Samples a 14-bit two-digit segment bus (tens/units), filters out transients by requiring the pattern to stay stable, decodes it back to a 4-bit value with error classification, and offers each new stable reading once over a valid/ready handshake. Used in self-check and loopback paths of the ALU display datapath.

## Interface
- STABLE_CYCLES, 4, consecutive extra sampling edges a pattern must stay unchanged before decode; legal range 1..255.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- displays  in  14  segment bus, active-low; [13:7] tens digit, [6:0] units digit; each digit ordered a..g with segment a at the digit MSB.
- out_ready  in  1  consumer accepts the offered reading.
- out_valid  out  1  reading offered.
- value  out  4  decoded value 0..15; 0 whenever err_code is non-zero.
- err_code  out  2  0 = ok, 1 = illegal tens pattern, 2 = illegal units pattern, 3 = out of range (16..19).
- err_count  out  8  saturating count of accepted transfers with err_code != 0.

## Operation
- Legal units patterns: 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100.
- Legal tens patterns: 0 = 0000001, 1 = 1001111. Any other tens pattern gives err 1.
- Error priority: err 1, then err 2, then err 3. Raw value = tens*10 + units in 5 bits; if raw > 15, err 3.
- Stability filter:
  - disp_q registers displays every edge.
  - If displays != disp_q, stab_cnt <= 0.
  - Otherwise stab_cnt increments, saturating at STABLE_CYCLES.
  - stable = (stab_cnt == STABLE_CYCLES).
- Change detection: last_pat holds the pattern of the last accepted transfer; have_last is cleared by reset.
- States:
  - TRACK: if stable and (!have_last or disp_q != last_pat), capture the decode of disp_q plus cap_pat <= disp_q, set out_valid, go to OFFER.
  - OFFER: value, err_code and cap_pat are frozen. Input changes only affect the filter. On out_valid && out_ready: clear out_valid, last_pat <= cap_pat, have_last <= 1, increment err_count if err_code != 0 (saturates at 255), go to TRACK.
- A pattern held indefinitely is emitted exactly once. Returning to a previously emitted but not-last pattern emits again.
- Reset values:
  - out_valid 0, value 0, err_code 0, err_count 0.
  - State TRACK, stab_cnt 0, disp_q 14'h3FFF (all segments off), have_last 0.
- Reset mid-OFFER abandons the reading with no transfer and no err_count change. The same pattern is re-emitted after release.

## Timing
- Pattern first sampled into disp_q at edge k and held: stable after edge k+STABLE_CYCLES; out_valid high after edge k+STABLE_CYCLES+1.
- A pattern lasting fewer than STABLE_CYCLES+1 consecutive edges is never emitted.
- out_valid stays high, with value and err_code constant, until the edge where out_ready is sampled high. out_valid falls after that edge.
- Minimum gap between transfers is one cycle low. If a different pattern is already stable at the transfer edge, out_valid re-rises after the following edge.
- out_ready is ignored while out_valid is low. There is no combinational path from any input to any output.

## Test plan
- Reset, STABLE_CYCLES = 4, out_ready = 1, displays = 0000001_0000100 first sampled at edge k and held 20 cycles → out_valid high for exactly one cycle after edge k+5, value 9, err_code 0; no further transfer.
- Hold 1001111_0100100 with out_ready = 0 for 20 cycles → out_valid held, value 15 constant. Change input to 1001111_0010010 at cycle 10. Raise out_ready → 15 transferred, out_valid low one cycle, then value 12 transferred.
- Alternate 0000001_0100100 / 0000001_0001111 every 2 cycles for 40 cycles → out_valid never asserts.
- Apply in turn 1001111_0100000, 1111111_0000001, 0000001_1111110, each held 10 cycles with out_ready = 1 → err_code 3, 1, 2 respectively, value 0 each time; err_count = 3.
- Apply stable 05, then 07, then 05 again → three transfers with values 5, 7, 5.
- Assert rst_n = 0 for one edge while in OFFER holding 13 → out_valid 0 after that edge, err_count unchanged. After release with the input still 13 → 13 re-emitted after STABLE_CYCLES+1 edges.
